traffic_phase_scheduler: RTL and testbench
==========================================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter CLOCK_HZ, default 5: clk cycles per one-second tick.
REQ-002 Parameter MAIN_GREEN, default 16: main-road green time, seconds.
REQ-003 Parameter SUB_GREEN, default 16: sub-road green time, seconds.
REQ-004 Parameter YELLOWT, default 3: yellow time per road, seconds.
REQ-005 Parameter RATIO_EXT, default 8: extra main green, seconds, when CarRatio set.
REQ-006 Parameter PED_MIN, default 5: green remaining after a pedestrian request truncates the phase, seconds.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 Pause  input  1  level; freezes the sequence while high.
REQ-010 Online  input  1  level; both roads in ONLINE (flash) mode while high; priority over Pause.
REQ-011 CarRatio  input  1  level; heavy main traffic, sampled at main-green entry.
REQ-012 PQm  input  1  one-cycle pulse; pedestrian request to cross the main road.
REQ-013 PQc  input  1  one-cycle pulse; pedestrian request to cross the sub road.
REQ-014 main_light_state, sub_light_state  output  3 each  codes RED=0, GREEN=1, YELLOW=2, ONLINE=3, PAUSE=4.
REQ-015 main_reset_time, sub_reset_time  output  5 each  remaining seconds shown on each road's display.
REQ-016 sec_tick  output  1  one-cycle pulse per elapsed second.

Function
REQ-017 Tick counter SHALL count 0..CLOCK_HZ-1 and wrap; sec_tick SHALL be high for the cycle in which the count equals CLOCK_HZ-1.
REQ-018 Phase FSM SHALL have states MG (main green/sub red), MY (main yellow/sub red), SG (sub green/main red), SY (sub yellow/main red), ONL, PAU; cycle order MG->MY->SG->SY->MG.
REQ-019 Phase entry SHALL load timer: MG = MAIN_GREEN (+RATIO_EXT if CarRatio=1 on the entry cycle); MY, SY = YELLOWT; SG = SUB_GREEN.
REQ-020 On sec_tick, timer>1 SHALL decrement; timer=1 SHALL advance to the next phase and load its time in the same cycle; timer never shows 0 in MG/MY/SG/SY.
REQ-021 Green/yellow road's reset_time SHALL equal timer; red road's reset_time SHALL equal timer+YELLOWT during the other road's green, timer during its yellow.
REQ-022 Both roads SHALL never be GREEN or YELLOW simultaneously.
REQ-023 PQm/PQc SHALL set sticky latches; a latch SHALL be cleared the cycle after it is honoured.
REQ-024 PQm latch honoured in MG, PQc latch in SG: if timer>PED_MIN, timer SHALL become PED_MIN next cycle, else unchanged; latch then clears.
REQ-025 A latch set outside its target green SHALL persist and be honoured on the first cycle of that green, after the entry load.
REQ-026 Online=1 SHALL move the FSM to ONL next cycle from any state, both light outputs = 3, both times = 0, tick counter held at 0, latches cleared.
REQ-027 Online falling SHALL enter MG with a fresh MAIN_GREEN load (CarRatio applies) and tick counter restarted from 0.
REQ-028 Pause=1 with Online=0 SHALL enter PAU next cycle: both light outputs = 4; timer, tick counter, and reset_time outputs frozen; PQm/PQc still latch.
REQ-029 Pause falling SHALL resume the exact frozen phase, timer and tick count.
REQ-030 A sec_tick coinciding with Pause or Online assertion SHALL take effect before the freeze/flush (timer decrement or phase advance completes).
REQ-031 MAIN_GREEN+RATIO_EXT+YELLOWT SHALL be at most 31; SUB_GREEN+YELLOWT SHALL be at most 31.

Reset
REQ-032 rst_n=0 SHALL immediately force: FSM=MG, timer=MAIN_GREEN, tick counter=0, latches cleared, sec_tick=0.
REQ-033 Reset outputs: main_light_state=1, sub_light_state=0, main_reset_time=16, sub_reset_time=19 (defaults).
REQ-034 Reset asserted mid-phase or mid-pause SHALL discard all state; sequence restarts at MG on the first rising edge after rst_n rises.

Verification
REQ-035 Defaults, CarRatio=0, run 40 s -> MG 16..1, MY 3..1, SG 16..1, SY 3..1, back to MG=16; sec_tick every 5 clk; sub_time 19 at reset.
REQ-036 CarRatio=1 at MG entry -> main 24..1, sub_time starts 27; CarRatio dropped mid-phase has no effect.
REQ-037 PQm pulse at MG timer=12 -> timer 5 next cycle; PQm pulse during SG -> MG entry loads 16 then drops to 5; PQm pulse at timer=3 -> unchanged.
REQ-038 Pause 3 s at SG timer=9, tick count 2 -> both lights 4, times frozen; release -> SG timer 9 resumes, next tick 3 cycles later.
REQ-039 Online pulse during MY with Pause also high -> lights 3, times 0; Online low -> MG 16, tick counter 0.
REQ-040 rst_n low 2 cycles asynchronously during SY -> outputs equal REQ-033 values before next clk edge.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler.
// Sequences main/sub green and yellow phases on a one-second tick, honours
// pedestrian requests by shortening the relevant green, and supports a
// flashing online mode and a full pause that resumes where it stopped.
module traffic_phase_scheduler #(
   parameter int CLOCK_HZ   = 5,
   parameter int MAIN_GREEN = 16,
   parameter int SUB_GREEN  = 16,
   parameter int YELLOWT    = 3,
   parameter int RATIO_EXT  = 8,
   parameter int PED_MIN    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Pause,
   input  logic       Online,
   input  logic       CarRatio,
   input  logic       PQm,
   input  logic       PQc,
   output logic [2:0] main_light_state,
   output logic [2:0] sub_light_state,
   output logic [4:0] main_reset_time,
   output logic [4:0] sub_reset_time,
   output logic       sec_tick
);

   // Phase encoding; the four running phases share a zero top bit
   localparam logic [2:0] ST_MG  = 3'd0;
   localparam logic [2:0] ST_MY  = 3'd1;
   localparam logic [2:0] ST_SG  = 3'd2;
   localparam logic [2:0] ST_SY  = 3'd3;
   localparam logic [2:0] ST_ONL = 3'd4;
   localparam logic [2:0] ST_PAU = 3'd5;

   localparam logic [2:0] LT_RED    = 3'd0;
   localparam logic [2:0] LT_GREEN  = 3'd1;
   localparam logic [2:0] LT_YELLOW = 3'd2;
   localparam logic [2:0] LT_ONLINE = 3'd3;
   localparam logic [2:0] LT_PAUSE  = 3'd4;

   localparam int TW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(CLOCK_HZ - 1);

   localparam logic [4:0] MG_LOAD     = 5'(MAIN_GREEN);
   localparam logic [4:0] MG_EXT_LOAD = 5'(MAIN_GREEN + RATIO_EXT);
   localparam logic [4:0] SG_LOAD     = 5'(SUB_GREEN);
   localparam logic [4:0] Y_LOAD      = 5'(YELLOWT);
   localparam logic [4:0] PED_LOAD    = 5'(PED_MIN);

   logic [2:0]    phase_q, phase_d;
   logic [2:0]    savedPhase_q, savedPhase_d;
   logic [4:0]    timer_q, timer_d;
   logic [TW-1:0] tickCount_q, tickCount_d;
   logic          pedMain_q, pedMain_d;
   logic          pedSub_q, pedSub_d;
   logic [2:0]    stepPhase;
   logic [4:0]    stepTimer;
   logic [2:0]    dispPhase;

   // Time loaded when a running phase is entered
   function automatic logic [4:0] entryLoad(input logic [2:0] ph, input logic car);
      case (ph)
         ST_MG:   entryLoad = car ? MG_EXT_LOAD : MG_LOAD;
         ST_SG:   entryLoad = SG_LOAD;
         default: entryLoad = Y_LOAD;
      endcase
   endfunction

   // The tick only fires in running phases, so a frozen counter never pulses
   assign sec_tick = ~phase_q[2] & (tickCount_q == TICK_LAST);

   // Next-state logic: online flush first, then pause handling, then the
   // running sequence where a coinciding tick completes before any freeze
   always_comb begin
      phase_d      = phase_q;
      savedPhase_d = savedPhase_q;
      timer_d      = timer_q;
      tickCount_d  = tickCount_q;
      pedMain_d    = pedMain_q | PQm;
      pedSub_d     = pedSub_q | PQc;
      stepPhase    = phase_q;
      stepTimer    = timer_q;
      if (Online) begin
         phase_d     = ST_ONL;
         tickCount_d = '0;
         pedMain_d   = 1'b0;
         pedSub_d    = 1'b0;
      end else if (phase_q == ST_ONL) begin
         phase_d     = ST_MG;
         timer_d     = entryLoad(ST_MG, CarRatio);
         tickCount_d = '0;
         pedMain_d   = 1'b0;
         pedSub_d    = 1'b0;
      end else if (phase_q == ST_PAU) begin
         if (!Pause) begin
            phase_d = savedPhase_q;
         end
      end else begin
         tickCount_d = sec_tick ? '0 : tickCount_q + TW'(1);
         if (sec_tick) begin
            if (timer_q > 5'd1) begin
               stepTimer = timer_q - 5'd1;
            end else begin
               stepPhase = {1'b0, phase_q[1:0] + 2'd1};
               stepTimer = entryLoad(stepPhase, CarRatio);
            end
         end
         if ((phase_q == ST_MG) && (pedMain_q || PQm)) begin
            pedMain_d = 1'b0;
            if (timer_q > PED_LOAD) begin
               stepTimer = PED_LOAD;
            end
         end
         if ((phase_q == ST_SG) && (pedSub_q || PQc)) begin
            pedSub_d = 1'b0;
            if (timer_q > PED_LOAD) begin
               stepTimer = PED_LOAD;
            end
         end
         timer_d = stepTimer;
         if (Pause) begin
            phase_d      = ST_PAU;
            savedPhase_d = stepPhase;
         end else begin
            phase_d = stepPhase;
         end
      end
   end

   // State registers; reset restarts the sequence at a fresh main green
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q      <= ST_MG;
         savedPhase_q <= ST_MG;
         timer_q      <= MG_LOAD;
         tickCount_q  <= '0;
         pedMain_q    <= 1'b0;
         pedSub_q     <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         savedPhase_q <= savedPhase_d;
         timer_q      <= timer_d;
         tickCount_q  <= tickCount_d;
         pedMain_q    <= pedMain_d;
         pedSub_q     <= pedSub_d;
      end
   end

   // Light codes and displayed times; a paused display shows the frozen phase
   always_comb begin
      dispPhase        = (phase_q == ST_PAU) ? savedPhase_q : phase_q;
      main_light_state = LT_RED;
      sub_light_state  = LT_RED;
      main_reset_time  = timer_q;
      sub_reset_time   = timer_q;
      case (dispPhase)
         ST_MG: begin
            main_light_state = LT_GREEN;
            sub_reset_time   = timer_q + Y_LOAD;
         end
         ST_MY: begin
            main_light_state = LT_YELLOW;
         end
         ST_SG: begin
            sub_light_state = LT_GREEN;
            main_reset_time = timer_q + Y_LOAD;
         end
         ST_SY: begin
            sub_light_state = LT_YELLOW;
         end
         default: begin
            main_reset_time = 5'd0;
            sub_reset_time  = 5'd0;
         end
      endcase
      if (phase_q == ST_PAU) begin
         main_light_state = LT_PAUSE;
         sub_light_state  = LT_PAUSE;
      end else if (phase_q == ST_ONL) begin
         main_light_state = LT_ONLINE;
         sub_light_state  = LT_ONLINE;
         main_reset_time  = 5'd0;
         sub_reset_time   = 5'd0;
      end
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized bench for traffic_phase_scheduler against a behavioural model
// that tracks mode, phase index, remaining seconds and pedestrian requests.
module tb_traffic_phase_scheduler;

   localparam int CLOCK_HZ   = 5;
   localparam int MAIN_GREEN = 16;
   localparam int SUB_GREEN  = 16;
   localparam int YELLOWT    = 3;
   localparam int RATIO_EXT  = 8;
   localparam int PED_MIN    = 5;

   localparam int MODE_RUN    = 0;
   localparam int MODE_PAUSE  = 1;
   localparam int MODE_ONLINE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       Pause = 1'b0;
   logic       Online = 1'b0;
   logic       CarRatio = 1'b0;
   logic       PQm = 1'b0;
   logic       PQc = 1'b0;
   logic [2:0] main_light_state;
   logic [2:0] sub_light_state;
   logic [4:0] main_reset_time;
   logic [4:0] sub_reset_time;
   logic       sec_tick;

   int numCompared = 0;
   int numMismatched = 0;

   int mMode;
   int mPh;
   int mTmr;
   int mCnt;
   bit mPm;
   bit mPc;

   traffic_phase_scheduler #(
      .CLOCK_HZ(CLOCK_HZ), .MAIN_GREEN(MAIN_GREEN), .SUB_GREEN(SUB_GREEN),
      .YELLOWT(YELLOWT), .RATIO_EXT(RATIO_EXT), .PED_MIN(PED_MIN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .Pause(Pause),
      .Online(Online),
      .CarRatio(CarRatio),
      .PQm(PQm),
      .PQc(PQc),
      .main_light_state(main_light_state),
      .sub_light_state(sub_light_state),
      .main_reset_time(main_reset_time),
      .sub_reset_time(sub_reset_time),
      .sec_tick(sec_tick)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic int loadFor(int ph, bit car);
      if (ph == 0) return MAIN_GREEN + (car ? RATIO_EXT : 0);
      if (ph == 2) return SUB_GREEN;
      return YELLOWT;
   endfunction

   task automatic modelReset();
      mMode = MODE_RUN;
      mPh   = 0;
      mTmr  = MAIN_GREEN;
      mCnt  = 0;
      mPm   = 1'b0;
      mPc   = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the inputs held across it
   task automatic modelStep();
      int oldPh;
      int oldT;
      bit tick;
      oldPh = mPh;
      oldT  = mTmr;
      if (Online) begin
         mMode = MODE_ONLINE;
         mCnt  = 0;
         mPm   = 1'b0;
         mPc   = 1'b0;
         return;
      end
      if (mMode == MODE_ONLINE) begin
         mMode = MODE_RUN;
         mPh   = 0;
         mTmr  = loadFor(0, CarRatio);
         mCnt  = 0;
         mPm   = 1'b0;
         mPc   = 1'b0;
         return;
      end
      mPm = mPm | PQm;
      mPc = mPc | PQc;
      if (mMode == MODE_PAUSE) begin
         if (!Pause) mMode = MODE_RUN;
         return;
      end
      tick = (mCnt == CLOCK_HZ - 1);
      mCnt = (mCnt + 1) % CLOCK_HZ;
      if (tick) begin
         if (oldT > 1) begin
            mTmr = oldT - 1;
         end else begin
            mPh  = (oldPh + 1) % 4;
            mTmr = loadFor(mPh, CarRatio);
         end
      end
      if (oldPh == 0 && mPm) begin
         if (oldT > PED_MIN) mTmr = PED_MIN;
         mPm = 1'b0;
      end
      if (oldPh == 2 && mPc) begin
         if (oldT > PED_MIN) mTmr = PED_MIN;
         mPc = 1'b0;
      end
      if (Pause) mMode = MODE_PAUSE;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      numCompared++;
      if (observed != expected) begin
         numMismatched++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   // Compare every output against the model's view of the current state
   task automatic checkAll();
      int expMainL;
      int expSubL;
      int expMainT;
      int expSubT;
      bit mainBusy;
      bit subBusy;
      expMainL = (mPh == 0) ? 1 : (mPh == 1) ? 2 : 0;
      expSubL  = (mPh == 2) ? 1 : (mPh == 3) ? 2 : 0;
      expMainT = (mPh == 2) ? mTmr + YELLOWT : mTmr;
      expSubT  = (mPh == 0) ? mTmr + YELLOWT : mTmr;
      if (mMode == MODE_PAUSE) begin
         expMainL = 4;
         expSubL  = 4;
      end else if (mMode == MODE_ONLINE) begin
         expMainL = 3;
         expSubL  = 3;
         expMainT = 0;
         expSubT  = 0;
      end
      checkOutput("main_light", int'(main_light_state), expMainL);
      checkOutput("sub_light", int'(sub_light_state), expSubL);
      checkOutput("main_time", int'(main_reset_time), expMainT);
      checkOutput("sub_time", int'(sub_reset_time), expSubT);
      checkOutput("sec_tick", int'(sec_tick), (mMode == MODE_RUN && mCnt == CLOCK_HZ - 1) ? 1 : 0);
      mainBusy = (main_light_state == 3'd1) || (main_light_state == 3'd2);
      subBusy  = (sub_light_state == 3'd1) || (sub_light_state == 3'd2);
      checkOutput("exclusive", int'(mainBusy && subBusy), 0);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must react at once
   task automatic midRunReset();
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst_main_light", int'(main_light_state), 1);
      checkOutput("async_rst_sub_light", int'(sub_light_state), 0);
      checkOutput("async_rst_main_time", int'(main_reset_time), MAIN_GREEN);
      checkOutput("async_rst_sub_time", int'(sub_reset_time), MAIN_GREEN + YELLOWT);
      checkOutput("async_rst_tick", int'(sec_tick), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      checkAll();
   endtask

   // Quiet directed window first, then random pause/online/pedestrian traffic
   task automatic applyStimulus(input int cyc);
      if (cyc < 200) begin
         Pause    = 1'b0;
         Online   = 1'b0;
         CarRatio = 1'b0;
         PQm      = 1'b0;
         PQc      = 1'b0;
      end else begin
         if ($urandom_range(0, 79) == 0) Pause = ~Pause;
         if (Online) begin
            if ($urandom_range(0, 9) == 0) Online = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            Online = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) CarRatio = $urandom_range(0, 1) == 1;
         PQm = ($urandom_range(0, 39) == 0);
         PQc = ($urandom_range(0, 39) == 0);
      end
   endtask

   initial begin
      modelReset();
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      checkOutput("reset_main_light", int'(main_light_state), 1);
      checkOutput("reset_sub_light", int'(sub_light_state), 0);
      checkOutput("reset_main_time", int'(main_reset_time), 16);
      checkOutput("reset_sub_time", int'(sub_reset_time), 19);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         checkAll();
         if (cyc == 1500 || cyc == 3000) midRunReset();
         applyStimulus(cyc);
         @(posedge clk);
         modelStep();
         @(negedge clk);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
